// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants and entry layout so Rename and Issue pack alloc/tag buses identically.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH  = 32;
   localparam int unsigned ROB_TAG_W  = 5;
   localparam int unsigned ROB_PHYS_W = 6;
   localparam int unsigned ROB_ARCH_W = 5;
   localparam int unsigned ROB_PC_W   = 32;

   typedef struct packed {
      logic [ROB_ARCH_W-1:0] arch;
      logic [ROB_PHYS_W-1:0] new_phys;
      logic [ROB_PHYS_W-1:0] old_phys;
      logic                  regwrite;
      logic                  store;
      logic [ROB_PC_W-1:0]   pc;
   } rob_entry_t;

   // x0 is hardwired, so its displaced mapping is never handed back to the free list.
   function automatic logic returns_mapping(input rob_entry_t e);
      return e.regwrite && (e.arch != '0);
   endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping TAG_W-bit slot pointer with increment and synchronous clear.
module reorder_buffer_rob_ptr #(
   parameter int unsigned TAG_W = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             inc,
   output logic [TAG_W-1:0] ptr
);

   logic [TAG_W-1:0] ptr_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ptr_q <= '0;
      end else if (clear) begin
         ptr_q <= '0;
      end else if (inc) begin
         ptr_q <= ptr_q + TAG_W'(1);
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement ROB: allocate at tail, complete by tag, retire one per cycle from head.
// Optional ROB_STATS_EN adds retire/full-cycle counters and a per-retire trace.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = ROB_DEPTH,
   parameter int unsigned TAG_W  = ROB_TAG_W,
   parameter int unsigned PHYS_W = ROB_PHYS_W,
   parameter int unsigned ARCH_W = ROB_ARCH_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              alloc_valid,
   input  logic [ARCH_W-1:0] alloc_arch_reg,
   input  logic [PHYS_W-1:0] alloc_new_phys,
   input  logic [PHYS_W-1:0] alloc_old_phys,
   input  logic              alloc_regwrite,
   input  logic              alloc_store,
   input  logic [31:0]       alloc_pc,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              rob_halt,
   input  logic              complete_valid,
   input  logic [TAG_W-1:0]  complete_tag,
   output logic              retire_valid,
   output logic [ARCH_W-1:0] retire_arch_reg,
   output logic [PHYS_W-1:0] retire_new_phys,
   output logic              return_map,
   output logic [PHYS_W-1:0] returned_mapping,
   output logic              retire_store,
   output logic [31:0]       retire_pc,
   output logic [TAG_W:0]    count,
   output logic              empty
`ifdef ROB_STATS_EN
   ,
   output logic [31:0]       stat_retired,
   output logic [31:0]       stat_full_cycles
`endif
);

   localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] valid_q, done_q;
   rob_entry_t       ent_q [DEPTH];
   logic [TAG_W:0]   count_q;
   logic [TAG_W-1:0] head, tail;
   rob_entry_t       head_ent;
   logic             alloc_ok, retire_ok;

   rob_entry_t       ret_q;
   logic             ret_valid_q, ret_map_q;
   logic [PHYS_W-1:0] ret_mapping_q;

   assign rob_halt  = (count_q == FullCount);
   assign head_ent  = ent_q[head];
   assign alloc_ok  = alloc_valid && !rob_halt && !FLUSH;
   assign retire_ok = valid_q[head] && done_q[head] && !FLUSH;

   reorder_buffer_rob_ptr #(.TAG_W(TAG_W)) u_head (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (FLUSH),
      .inc   (retire_ok),
      .ptr   (head)
   );

   reorder_buffer_rob_ptr #(.TAG_W(TAG_W)) u_tail (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (FLUSH),
      .inc   (alloc_ok),
      .ptr   (tail)
   );

   // Later writes win: a retiring head clears done even if completed again this edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= '0;
         done_q  <= '0;
         count_q <= '0;
      end else if (FLUSH) begin
         valid_q <= '0;
         done_q  <= '0;
         count_q <= '0;
      end else begin
         if (complete_valid && valid_q[complete_tag]) begin
            done_q[complete_tag] <= 1'b1;
         end
         if (retire_ok) begin
            valid_q[head] <= 1'b0;
            done_q[head]  <= 1'b0;
         end
         if (alloc_ok) begin
            valid_q[tail] <= 1'b1;
            done_q[tail]  <= 1'b0;
         end
         count_q <= count_q + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(retire_ok);
      end
   end

   always_ff @(posedge CLK) begin
      if (alloc_ok) begin
         ent_q[tail] <= '{arch:     alloc_arch_reg,
                          new_phys: alloc_new_phys,
                          old_phys: alloc_old_phys,
                          regwrite: alloc_regwrite,
                          store:    alloc_store,
                          pc:       alloc_pc};
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ret_valid_q   <= 1'b0;
         ret_q         <= '0;
         ret_map_q     <= 1'b0;
         ret_mapping_q <= '0;
      end else begin
         ret_valid_q   <= retire_ok;
         ret_q         <= retire_ok ? head_ent : '0;
         ret_map_q     <= retire_ok && returns_mapping(head_ent);
         ret_mapping_q <= (retire_ok && returns_mapping(head_ent)) ? head_ent.old_phys : '0;
      end
   end

   assign alloc_tag        = tail;
   assign count            = count_q;
   assign empty            = (count_q == '0);
   assign retire_valid     = ret_valid_q;
   assign retire_arch_reg  = ret_q.arch;
   assign retire_new_phys  = ret_q.new_phys;
   assign retire_store     = ret_q.store;
   assign retire_pc        = ret_q.pc;
   assign return_map       = ret_map_q;
   assign returned_mapping = ret_mapping_q;

`ifdef ROB_STATS_EN
   logic [31:0] stat_retired_q, stat_full_q;

   // Counters survive FLUSH; only RESET clears them.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stat_retired_q <= '0;
         stat_full_q    <= '0;
      end else begin
         if (ret_valid_q) stat_retired_q <= stat_retired_q + 32'd1;
         if (rob_halt)    stat_full_q    <= stat_full_q + 32'd1;
      end
   end

   assign stat_retired     = stat_retired_q;
   assign stat_full_cycles = stat_full_q;

   always_ff @(posedge CLK) begin
      if (RESET && ret_valid_q) begin
         $display("rob retire pc=%08h arch=%0d phys=%0d", ret_q.pc, ret_q.arch, ret_q.new_phys);
      end
   end
`endif

endmodule
